// File: rtl/decode_execute_reg_if.sv
// Decode->Execute bundle: Decode-side inputs, write-back snoop, Execute-side copies.
// The slave modport belongs to the pipeline register; the master to its environment.
interface decode_execute_reg_if #(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 3
);
  logic                 stall_d;
  logic                 flush_e;
  logic                 valid_d;
  logic [XLEN-1:0]      RD1D;
  logic [XLEN-1:0]      RD2D;
  logic [XLEN-1:0]      ImmExtD;
  logic [XLEN-1:0]      PCD;
  logic [XLEN-1:0]      PCPlus4D;
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  logic [4:0]           RdD;
  logic                 RegWriteD;
  logic                 MemWriteD;
  logic [1:0]           ResultSrcD;
  logic                 BranchD;
  logic                 JumpD;
  logic                 ALUSrcD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic                 RegWriteW;
  logic [4:0]           RdW;
  logic [XLEN-1:0]      ResultW;

  logic                 valid_e;
  logic [XLEN-1:0]      RD1E;
  logic [XLEN-1:0]      RD2E;
  logic [XLEN-1:0]      ImmExtE;
  logic [XLEN-1:0]      PCE;
  logic [XLEN-1:0]      PCPlus4E;
  logic [4:0]           Rs1E;
  logic [4:0]           Rs2E;
  logic [4:0]           RdE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic [1:0]           ResultSrcE;
  logic                 BranchE;
  logic                 JumpE;
  logic                 ALUSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;

  modport master (
    output stall_d, flush_e, valid_d,
    output RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
    output Rs1D, Rs2D, RdD,
    output RegWriteD, MemWriteD, ResultSrcD,
    output BranchD, JumpD, ALUSrcD, ALUControlD,
    output RegWriteW, RdW, ResultW,
    input  valid_e, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    input  Rs1E, Rs2E, RdE,
    input  RegWriteE, MemWriteE, ResultSrcE,
    input  BranchE, JumpE, ALUSrcE, ALUControlE
  );

  modport slave (
    input  stall_d, flush_e, valid_d,
    input  RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
    input  Rs1D, Rs2D, RdD,
    input  RegWriteD, MemWriteD, ResultSrcD,
    input  BranchD, JumpD, ALUSrcD, ALUControlD,
    input  RegWriteW, RdW, ResultW,
    output valid_e, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    output Rs1E, Rs2E, RdE,
    output RegWriteE, MemWriteE, ResultSrcE,
    output BranchE, JumpE, ALUSrcE, ALUControlE
  );
endinterface

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with flush > stall > capture priority.
// DECODE_EXECUTE_WB_BYPASS_EN adds the same-edge write-back bypass on RD1/RD2.
module decode_execute_reg #(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 3
) (
  input  logic clk,
  input  logic rst,
  decode_execute_reg_if.slave bus
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pcp4;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 regw;
    logic                 memw;
    logic [1:0]           rsrc;
    logic                 br;
    logic                 jmp;
    logic                 alusrc;
    logic [ALUCTRL_W-1:0] aluc;
  } ex_t;

  ex_t             ex_d, ex_q, cap;
  logic [XLEN-1:0] rd1_fwd, rd2_fwd;

`ifdef DECODE_EXECUTE_WB_BYPASS_EN
  // x0 reads as zero; a nonzero Rs match implies RdW != 0.
  always_comb begin
    rd1_fwd = bus.RD1D;
    rd2_fwd = bus.RD2D;
    if (bus.Rs1D == 5'd0)
      rd1_fwd = '0;
    else if (bus.RegWriteW && bus.RdW == bus.Rs1D)
      rd1_fwd = bus.ResultW;
    if (bus.Rs2D == 5'd0)
      rd2_fwd = '0;
    else if (bus.RegWriteW && bus.RdW == bus.Rs2D)
      rd2_fwd = bus.ResultW;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.RegWriteW, bus.RdW, bus.ResultW};
  assign rd1_fwd   = bus.RD1D;
  assign rd2_fwd   = bus.RD2D;
`endif

  always_comb begin
    cap.valid  = bus.valid_d;
    cap.rd1    = rd1_fwd;
    cap.rd2    = rd2_fwd;
    cap.imm    = bus.ImmExtD;
    cap.pc     = bus.PCD;
    cap.pcp4   = bus.PCPlus4D;
    cap.rs1    = bus.Rs1D;
    cap.rs2    = bus.Rs2D;
    cap.rd     = bus.RdD;
    cap.regw   = bus.RegWriteD & bus.valid_d;
    cap.memw   = bus.MemWriteD & bus.valid_d;
    cap.rsrc   = bus.ResultSrcD;
    cap.br     = bus.BranchD & bus.valid_d;
    cap.jmp    = bus.JumpD & bus.valid_d;
    cap.alusrc = bus.ALUSrcD;
    cap.aluc   = bus.ALUControlD;
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.flush_e)
      ex_d = '0;
    else if (!bus.stall_d)
      ex_d = cap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign bus.valid_e     = ex_q.valid;
  assign bus.RD1E        = ex_q.rd1;
  assign bus.RD2E        = ex_q.rd2;
  assign bus.ImmExtE     = ex_q.imm;
  assign bus.PCE         = ex_q.pc;
  assign bus.PCPlus4E    = ex_q.pcp4;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.RdE         = ex_q.rd;
  assign bus.RegWriteE   = ex_q.regw;
  assign bus.MemWriteE   = ex_q.memw;
  assign bus.ResultSrcE  = ex_q.rsrc;
  assign bus.BranchE     = ex_q.br;
  assign bus.JumpE       = ex_q.jmp;
  assign bus.ALUSrcE     = ex_q.alusrc;
  assign bus.ALUControlE = ex_q.aluc;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg.
// Expected E-bundles are queued at drive time and popped after each edge.
module tb_decode_execute_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regw;
    logic        memw;
    logic [1:0]  rsrc;
    logic        br;
    logic        jmp;
    logic        alusrc;
    logic [2:0]  aluc;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  ex_t  sb[$];
  ex_t  got, exp;

  decode_execute_reg_if #(.XLEN(32), .ALUCTRL_W(3)) bus ();

  decode_execute_reg #(.XLEN(32), .ALUCTRL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic ex_t sample();
    ex_t s;
    s.valid  = bus.valid_e;
    s.rd1    = bus.RD1E;
    s.rd2    = bus.RD2E;
    s.imm    = bus.ImmExtE;
    s.pc     = bus.PCE;
    s.pcp4   = bus.PCPlus4E;
    s.rs1    = bus.Rs1E;
    s.rs2    = bus.Rs2E;
    s.rd     = bus.RdE;
    s.regw   = bus.RegWriteE;
    s.memw   = bus.MemWriteE;
    s.rsrc   = bus.ResultSrcE;
    s.br     = bus.BranchE;
    s.jmp    = bus.JumpE;
    s.alusrc = bus.ALUSrcE;
    s.aluc   = bus.ALUControlE;
    return s;
  endfunction

  function automatic ex_t rnd_d();
    ex_t d;
    d.valid  = 1'($urandom_range(1, 0));
    d.rd1    = $urandom;
    d.rd2    = $urandom;
    d.imm    = $urandom;
    d.pc     = $urandom;
    d.pcp4   = $urandom;
    d.rs1    = 5'($urandom_range(31, 1));
    d.rs2    = 5'($urandom_range(31, 1));
    d.rd     = 5'($urandom_range(31, 0));
    d.regw   = 1'($urandom_range(1, 0));
    d.memw   = 1'($urandom_range(1, 0));
    d.rsrc   = 2'($urandom_range(3, 0));
    d.br     = 1'($urandom_range(1, 0));
    d.jmp    = 1'($urandom_range(1, 0));
    d.alusrc = 1'($urandom_range(1, 0));
    d.aluc   = 3'($urandom_range(7, 0));
    return d;
  endfunction

  // Bubble rule: side-effecting controls vanish when Decode is not valid.
  function automatic ex_t bubble(ex_t d);
    ex_t e = d;
    if (!d.valid) begin
      e.regw = 1'b0;
      e.memw = 1'b0;
      e.br   = 1'b0;
      e.jmp  = 1'b0;
    end
    return e;
  endfunction

  task automatic apply(ex_t d, logic stall, logic flush);
    bus.stall_d     = stall;
    bus.flush_e     = flush;
    bus.valid_d     = d.valid;
    bus.RD1D        = d.rd1;
    bus.RD2D        = d.rd2;
    bus.ImmExtD     = d.imm;
    bus.PCD         = d.pc;
    bus.PCPlus4D    = d.pcp4;
    bus.Rs1D        = d.rs1;
    bus.Rs2D        = d.rs2;
    bus.RdD         = d.rd;
    bus.RegWriteD   = d.regw;
    bus.MemWriteD   = d.memw;
    bus.ResultSrcD  = d.rsrc;
    bus.BranchD     = d.br;
    bus.JumpD       = d.jmp;
    bus.ALUSrcD     = d.alusrc;
    bus.ALUControlD = d.aluc;
  endtask

  function automatic ex_t flow_d();
    ex_t d = '0;
    d.valid = 1'b1;
    d.rd1   = 32'h20;
    d.rd2   = 32'h5;
    d.rd    = 5'd9;
    d.regw  = 1'b1;
    d.rs1   = 5'd1;
    d.rs2   = 5'd2;
    return d;
  endfunction

  task automatic test_reset();
    ex_t d;
    rst = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.RdW       = 5'd0;
    bus.ResultW   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(rnd_d(), 1'($urandom_range(1, 0)), 1'b0);
      sb.push_back('0);
      @(posedge clk); #1;
      exp = sb.pop_front(); got = sample(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    d = rnd_d();
    d.valid = 1'b1;
    apply(d, 1'b0, 1'b0);
    sb.push_back(d);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_first_capture got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('0);
    #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", got, exp);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_flow();
    ex_t d = flow_d();
    @(negedge clk);
    apply(d, 1'b0, 1'b0);
    sb.push_back(d);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flow got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_stall();
    ex_t d = flow_d();
    ex_t held;
    @(negedge clk);
    apply(d, 1'b0, 1'b0);
    sb.push_back(d);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stall_load got=%h exp=%h", got, exp);
    end
    held = d;
    d.rd1 = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      apply(d, 1'b1, 1'b0);
      sb.push_back(held);
      @(posedge clk); #1;
      exp = sb.pop_front(); got = sample(); n_tests++;
      if (got.rd1 !== 32'h20 || got !== exp) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    @(negedge clk);
    apply(d, 1'b0, 1'b0);
    sb.push_back(d);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got.rd1 !== 32'hDEAD || got !== exp) begin
      n_fail++;
      $display("FAIL stall_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_flush();
    ex_t d = flow_d();
    d.memw = 1'b1;
    d.br   = 1'b1;
    @(negedge clk);
    apply(d, 1'b1, 1'b1);
    sb.push_back('0);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_over_stall got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_bubble();
    ex_t d = rnd_d();
    ex_t e;
    d.valid  = 1'b0;
    d.regw   = 1'b1;
    d.jmp    = 1'b1;
    d.memw   = 1'b1;
    d.br     = 1'b1;
    d.rd2    = 32'h4;
    d.rsrc   = 2'd2;
    d.alusrc = 1'b1;
    d.aluc   = 3'd5;
    e = d;
    e.regw = 1'b0;
    e.jmp  = 1'b0;
    e.memw = 1'b0;
    e.br   = 1'b0;
    @(negedge clk);
    apply(d, 1'b0, 1'b0);
    sb.push_back(e);
    @(posedge clk); #1;
    exp = sb.pop_front(); got = sample(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL bubble got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_bypass();
    ex_t d = flow_d();
    logic [4:0]  rs1_v[3];
    logic [31:0] rd1_v[3];
    logic [4:0]  rdw_v[3];
    logic [31:0] want[3];
    rs1_v = '{5'd9, 5'd9, 5'd0};
    rd1_v = '{32'h20, 32'h20, 32'h55};
    rdw_v = '{5'd9, 5'd0, 5'd0};
`ifdef DECODE_EXECUTE_WB_BYPASS_EN
    want  = '{32'h77, 32'h20, 32'h0};
`else
    want  = '{32'h20, 32'h20, 32'h55};
`endif
    for (int i = 0; i < 3; i++) begin
      d.rs1 = rs1_v[i];
      d.rd1 = rd1_v[i];
      @(negedge clk);
      apply(d, 1'b0, 1'b0);
      bus.RegWriteW = 1'b1;
      bus.RdW       = rdw_v[i];
      bus.ResultW   = 32'h77;
      exp = d;
      exp.rd1 = want[i];
      sb.push_back(exp);
      @(posedge clk); #1;
      exp = sb.pop_front(); got = sample(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bypass[%0d] rd1 got=%h exp=%h", i, got.rd1, exp.rd1);
      end
    end
    @(negedge clk);
    bus.RegWriteW = 1'b0;
    bus.RdW       = 5'd0;
  endtask

  task automatic test_back_to_back();
    ex_t cur = '0;
    ex_t d;
    logic st, fl;
    for (int i = 0; i < 24; i++) begin
      d  = rnd_d();
      fl = (i == 0) || ($urandom_range(5, 0) == 0);
      st = 1'($urandom_range(2, 0) == 0);
      if (fl)
        cur = '0;
      else if (!st)
        cur = bubble(d);
      @(negedge clk);
      apply(d, st, fl);
      sb.push_back(cur);
      @(posedge clk); #1;
      exp = sb.pop_front(); got = sample(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] st=%0b fl=%0b got=%h exp=%h",
                 i, st, fl, got, exp);
      end
    end
  endtask

  initial begin
    apply('0, 1'b0, 1'b0);
    test_reset();
    test_flow();
    test_stall();
    test_flush();
    test_bubble();
    test_bypass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Decode→Execute pipeline register of the 5-stage RV32I core.
- Captures the register-file read data (RD1/RD2), immediate, PC and decoded control for the instruction in Decode, and presents them to the ALU/branch stage one cycle later.
- Provides stall (hold) and flush (bubble) control for the hazard unit, with an optional write-back bypass that covers the same-cycle write/read case of the register file.

Parameters:
XLEN, 32, datapath width of RD1/RD2/imm/PC.
ALUCTRL_W, 3, width of ALU control field.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
stall_d  input  1  hold all E outputs this edge
flush_e  input  1  load a bubble this edge
valid_d  input  1  Decode holds a real instruction
RD1D  input  XLEN  register-file port-1 read data
RD2D  input  XLEN  register-file port-2 read data
ImmExtD  input  XLEN  sign-extended immediate
PCD  input  XLEN  instruction PC
PCPlus4D  input  XLEN  PC+4
Rs1D  input  5  source reg 1 index
Rs2D  input  5  source reg 2 index
RdD  input  5  destination index
RegWriteD  input  1  control: writes rd
MemWriteD  input  1  control: store
ResultSrcD  input  2  control: result mux select
BranchD  input  1  control: branch
JumpD  input  1  control: jal/jalr
ALUSrcD  input  1  control: ALU B = imm
ALUControlD  input  ALUCTRL_W  ALU operation
RegWriteW  input  1  write-back enable (same as register-file write enable)
RdW  input  5  write-back index
ResultW  input  XLEN  write-back data
valid_e, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, ALUControlE  output  (width as D counterpart)  registered Execute-stage copies

Behaviour:
- All outputs are registers; no combinational path from any input to any output.
- Reset (rst=0, asynchronous, effective immediately without a clock edge): every output = 0, valid_e = 0.
- Priority at each posedge clk with rst=1: flush_e > stall_d > capture.
- Flush: valid_e ← 0; RegWriteE, MemWriteE, BranchE, JumpE ← 0; all other outputs ← 0.
- Stall (flush_e=0, stall_d=1): every output holds its value; no bypass is applied to held values.
- Capture (flush_e=0, stall_d=0): every E output ← its D input (1-cycle latency); valid_e ← valid_d.
- Capture with valid_d=0: RegWriteE, MemWriteE, BranchE, JumpE forced to 0 (bubble); data fields still captured.
- Simultaneous flush_e=1 and stall_d=1: flush wins.
- Reset asserted mid-stall or mid-flush: outputs clear at once. First capture happens on the first posedge after rst returns to 1.
- ResultSrcE, ALUSrcE, ALUControlE carry no side effects and are not forced on a bubble (they are only zeroed by flush or reset).

Optional Feature:
- Macro: DECODE_EXECUTE_WB_BYPASS_EN.
- Defined:
  - On capture, if RegWriteW=1, RdW≠0 and RdW==Rs1D, then RD1E ← ResultW instead of RD1D; same rule for Rs2D/RD2E.
  - If Rs1D==0, RD1E ← 0 (likewise Rs2D/RD2E), regardless of RD1D.
  - Covers the register file writing at the same edge as Decode reads.
- Undefined: RD1E/RD2E always capture RD1D/RD2D unmodified; RegWriteW, RdW, ResultW are unused.

Test Plan:
1. Reset: rst=0 for 3 cycles with random inputs → all outputs 0, valid_e=0. Assert rst=0 between edges → outputs clear before the next edge.
2. Pipeline flow: valid_d=1, RD1D=32'h20, RD2D=32'h5, RdD=9, RegWriteD=1 → after one edge RD1E=32'h20, RD2E=32'h5, RdE=9, RegWriteE=1, valid_e=1.
3. Stall: load the case-2 values, then stall_d=1 for 2 cycles while RD1D=32'hDEAD → RD1E stays 32'h20. Release stall → RD1E=32'hDEAD next edge.
4. Flush precedence: flush_e=1, stall_d=1, MemWriteD=1, BranchD=1 → valid_e=0, MemWriteE=0, BranchE=0, RD1E=0.
5. Bubble: valid_d=0, RegWriteD=1, JumpD=1, RD2D=32'h4 → RegWriteE=0, JumpE=0, valid_e=0, RD2E=32'h4.
6. Bypass (macro defined): Rs1D=9, RD1D=32'h20, RegWriteW=1, RdW=9, ResultW=32'h77 → RD1E=32'h77. Repeat with RdW=0 → RD1E=32'h20. Repeat with Rs1D=0, RD1D=32'h55 → RD1E=0. Without the macro, the first case gives RD1E=32'h20.
